// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 constants and decode helpers for the load/store unit
// Purpose: FSM state and access-size types, RV32I load/store funct3 encodings,
//          funct3 legality and size decode used by load_store_unit.
// Ports:   none (package).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // x11 has no size encoding; 11x would be an unsigned word, which RV32I lacks.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11);
  endfunction

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane mask, write shift and load extract/extend (combinational)
// Purpose: maps a byte offset and access size onto an 8-lane (two-word) window.
// Ports:   i_off      byte offset within word0
//          i_size     access size (lsu_size_e encoding)
//          i_unsigned zero-extend loads when 1
//          i_wdata    LSB-aligned store data
//          i_hi/i_lo  word1 / word0 read data (i_hi = 0 for unsplit loads)
//          o_mask8    byte enables, [3:0] word0, [7:4] word1
//          o_wide     shifted store data, [31:0] word0, [63:32] word1
//          o_split    access crosses into word1
//          o_rdata    extracted, extended load result
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [7:0]  o_mask8,
  output logic [63:0] o_wide,
  output logic        o_split,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_base;
  logic [5:0]  w_shift;
  logic [31:0] w_rd;

  always_comb begin
    case (lsu_size_e'(i_size))
      SZ_B:    w_base = 8'h01;
      SZ_H:    w_base = 8'h03;
      default: w_base = 8'h0F;
    endcase
  end

  assign w_shift = {i_off, 3'b000};
  assign o_mask8 = w_base << i_off;
  assign o_wide  = {32'h0, i_wdata} << w_shift;
  // Any enabled lane in the upper word means a second RAM cycle is needed.
  assign o_split = |o_mask8[7:4];

  assign w_rd = 32'({i_hi, i_lo} >> w_shift);

  always_comb begin
    case (lsu_size_e'(i_size))
      SZ_B:    o_rdata = {{24{~i_unsigned & w_rd[7]}}, w_rd[7:0]};
      SZ_H:    o_rdata = {{16{~i_unsigned & w_rd[15]}}, w_rd[15:0]};
      default: o_rdata = w_rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory-access stage with misaligned split into two word cycles
// Purpose: accepts one load/store from execute, drives the byte-lane data RAM for one
//          or two cycles, returns extended load data with a one-cycle resp_valid pulse.
// Ports:   clk, rst_n                    clock, synchronous active-low reset
//          req_valid/req_ready           request handshake (ready only in IDLE)
//          req_we/req_funct3/req_addr/req_wdata  request fields
//          resp_valid/resp_err/resp_rdata       completion pulse, illegal flag, load data
//          mem_en/mem_we/mem_be/mem_addr/mem_wdata  RAM command
//          mem_rdata                     RAM read data, one cycle after a read
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-3:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  lsu_state_e            r_state;
  lsu_state_e            w_state_nxt;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_hold;
  logic                  r_resp_valid;
  logic                  r_resp_err;

  logic                  w_accept;
  logic                  w_illegal;
  logic [7:0]            w_mask8;
  logic [63:0]           w_wide;
  logic                  w_split;
  logic [31:0]           w_hi;
  logic [31:0]           w_lo;
  logic [31:0]           w_rdata;
  logic [ADDR_WIDTH-3:0] w_word0;
  logic [ADDR_WIDTH-3:0] w_word1;
  logic                  w_acc1;
  logic                  w_acc2;
  logic                  w_unused;

  assign w_unused  = ^req_addr[31:ADDR_WIDTH];

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_ready && req_valid;
  assign w_illegal = f3_illegal(req_funct3);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = w_illegal ? RESP : ACC1;
      ACC1:    w_state_nxt = w_split ? ACC2 : RESP;
      ACC2:    w_state_nxt = RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_hold       <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_valid <= (w_state_nxt == RESP);
      r_resp_err   <= w_accept && w_illegal;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr[ADDR_WIDTH-1:0];
        r_wdata <= req_wdata;
      end
      // In ACC2 the RAM is presenting word0, read during ACC1.
      if (r_state == ACC2) r_hold <= mem_rdata;
    end
  end

  lsu_lane_align u_align (
    .i_off      (r_addr[1:0]),
    .i_size     (f3_size(r_f3)),
    .i_unsigned (r_f3[2]),
    .i_wdata    (r_wdata),
    .i_hi       (w_hi),
    .i_lo       (w_lo),
    .o_mask8    (w_mask8),
    .o_wide     (w_wide),
    .o_split    (w_split),
    .o_rdata    (w_rdata)
  );

  // In RESP the RAM presents the last word read: word1 when split, word0 otherwise.
  assign w_hi = w_split ? mem_rdata : 32'h0;
  assign w_lo = w_split ? r_hold : mem_rdata;

  assign w_word0 = r_addr[ADDR_WIDTH-1:2];
  assign w_word1 = w_word0 + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  // Gating with rst_n keeps a reset asserted mid-access from issuing that cycle's write.
  assign w_acc1 = rst_n && (r_state == ACC1);
  assign w_acc2 = rst_n && (r_state == ACC2);

  assign mem_en    = w_acc1 || w_acc2;
  assign mem_we    = mem_en && r_we;
  assign mem_be    = w_acc1 ? w_mask8[3:0]  : (w_acc2 ? w_mask8[7:4]   : 4'h0);
  assign mem_addr  = w_acc1 ? w_word0       : (w_acc2 ? w_word1        : '0);
  assign mem_wdata = w_acc1 ? w_wide[31:0]  : (w_acc2 ? w_wide[63:32]  : 32'h0);

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = (r_resp_valid && !r_resp_err && !r_we) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW = 17;
  localparam int NW = 1 << (AW - 2);
  localparam int NB = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] ram [NW];
  logic [7:0]  sh  [NB];

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q [$];
  logic [32:0] e;
  logic [AW-3:0] lg_addr [$];
  logic [3:0]    lg_be   [$];
  logic [31:0]   lg_wd   [$];
  logic          lg_we   [$];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-lane RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) ram[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      lg_addr.push_back(mem_addr);
      lg_be.push_back(mem_be);
      lg_wd.push_back(mem_wdata);
      lg_we.push_back(mem_we);
    end
    if (resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp err=%0b rdata=%h required=none", resp_err, resp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          errors++;
          $display("FAIL resp got err=%0b rdata=%h required err=%0b rdata=%h",
                   resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic is_bad(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] v = 32'h0;
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = sh[(addr + i) & (NB - 1)];
    if (!f3[2]) begin
      if (n == 1) v = {{24{v[7]}}, v[7:0]};
      else if (n == 2) v = {{16{v[15]}}, v[15:0]};
    end
    return v;
  endfunction

  function automatic int model_lat(input logic [31:0] addr, input logic [2:0] f3);
    if (is_bad(f3)) return 1;
    return (int'(addr[1:0]) + nbytes(f3) > 4) ? 3 : 2;
  endfunction

  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd,
                           input int exp_lat, input string name);
    int k = 0;
    logic got = 1'b0;
    logic bad = is_bad(f3);
    lg_addr.delete(); lg_be.delete(); lg_wd.delete(); lg_we.delete();
    @(negedge clk);
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout got=%b required=1", name, req_ready);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    exp_q.push_back({bad, (bad || we) ? 32'h0 : exp_rd});
    if (we && !bad)
      for (int i = 0; i < nbytes(f3); i++) sh[(addr + i) & (NB - 1)] = wdata[8*i +: 8];
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        checks++;
        if (c != exp_lat) begin
          errors++;
          $display("FAIL %s latency got=%0d required=%0d", name, c, exp_lat);
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s resp_timeout got=none required=resp_valid", name);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctl got ready/valid/err/en=%b required=1000",
               {req_ready, resp_valid, resp_err, mem_en});
    end
    checks++;
    if (resp_rdata !== 32'h0 || mem_be !== 4'h0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h be=%h required 0", resp_rdata, mem_be);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_aligned();
    do_access(1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 32'h0, 2, "sw_10");
    checks++;
    if (lg_addr.size() != 1 || lg_addr[0] !== 15'd4 || lg_be[0] !== 4'hF ||
        lg_wd[0] !== 32'hDEADBEEF || lg_we[0] !== 1'b1) begin
      errors++;
      $display("FAIL sw_10_mem got n=%0d addr=%0d be=%h wd=%h required n=1 addr=4 be=f wd=deadbeef",
               lg_addr.size(), lg_addr[0], lg_be[0], lg_wd[0]);
    end
    do_access(1'b0, F3_LW, 32'h10, 32'h0, 32'hDEADBEEF, 2, "lw_10");
  endtask

  task automatic test_subword();
    do_access(1'b0, F3_LB,  32'h13, 32'h0, 32'hFFFFFFDE, 2, "lb_13");
    do_access(1'b0, F3_LBU, 32'h13, 32'h0, 32'h000000DE, 2, "lbu_13");
    do_access(1'b0, F3_LH,  32'h12, 32'h0, 32'hFFFFDEAD, 2, "lh_12");
    do_access(1'b0, F3_LHU, 32'h10, 32'h0, 32'h0000BEEF, 2, "lhu_10");
  endtask

  task automatic test_split_load();
    do_access(1'b1, F3_SW, 32'h14, 32'h11223344, 32'h0, 2, "sw_14");
    do_access(1'b0, F3_LW, 32'h12, 32'h0, 32'h3344DEAD, 3, "lw_12");
    checks++;
    if (lg_addr.size() != 2 || lg_addr[0] !== 15'd4 || lg_addr[1] !== 15'd5) begin
      errors++;
      $display("FAIL lw_12_mem got n=%0d required n=2 addr 4,5", lg_addr.size());
    end
  endtask

  task automatic test_split_store();
    do_access(1'b1, F3_SH, 32'h13, 32'h0000A55A, 32'h0, 3, "sh_13");
    checks++;
    if (lg_addr.size() != 2 || lg_addr[0] !== 15'd4 || lg_be[0] !== 4'b1000 ||
        lg_wd[0][31:24] !== 8'h5A || lg_addr[1] !== 15'd5 || lg_be[1] !== 4'b0001 ||
        lg_wd[1][7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL sh_13_mem got n=%0d be0=%h wd0=%h be1=%h wd1=%h required be 8/1 lanes 5a/a5",
               lg_addr.size(), lg_be[0], lg_wd[0], lg_be[1], lg_wd[1]);
    end
    do_access(1'b0, F3_LHU, 32'h13, 32'h0, 32'h0000A55A, 3, "lhu_13");
  endtask

  task automatic test_illegal();
    do_access(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "f3_011");
    checks++;
    if (lg_addr.size() != 0) begin
      errors++;
      $display("FAIL f3_011_mem got n=%0d required n=0", lg_addr.size());
    end
    do_access(1'b1, 3'b110, 32'h20, 32'h12345678, 32'h0, 1, "f3_110");
    checks++;
    if (lg_addr.size() != 0) begin
      errors++;
      $display("FAIL f3_110_mem got n=%0d required n=0", lg_addr.size());
    end
  endtask

  task automatic test_wrap();
    do_access(1'b1, F3_SW, 32'h1FFFC, 32'hA1B2C3D4, 32'h0, 2, "sw_top");
    do_access(1'b1, F3_SW, 32'h0, 32'h55667788, 32'h0, 2, "sw_0");
    do_access(1'b0, F3_LW, 32'h1FFFE, 32'h0, 32'h7788A1B2, 3, "lw_wrap");
    checks++;
    if (lg_addr.size() != 2 || lg_addr[0] !== 15'h7FFF || lg_addr[1] !== 15'd0) begin
      errors++;
      $display("FAIL lw_wrap_mem got n=%0d required addr 7fff then 0", lg_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 30; i++) begin
      logic we = 1'($urandom_range(0, 1));
      logic [2:0] f3 = (i % 9 == 8) ? 3'b111 : legal[$urandom_range(0, 4)];
      logic [31:0] a = 32'h40 + $urandom_range(0, 59);
      logic [31:0] wd = $urandom;
      a[24] = 1'($urandom_range(0, 1));
      do_access(we, f3, a, wd, we ? 32'h0 : model_load(a, f3), model_lat(a, f3), "rand");
    end
  endtask

  task automatic test_reset_split();
    int k = 0;
    lg_addr.delete(); lg_be.delete(); lg_wd.delete(); lg_we.delete();
    @(negedge clk);
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW;
    req_addr = 32'h22; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 15'd8 || mem_be !== 4'b1100) begin
      errors++;
      $display("FAIL rst_acc1 got en=%b addr=%0d be=%h required en=1 addr=8 be=c",
               mem_en, mem_addr, mem_be);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc2_en got=%b required=0", mem_en);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release got ready=%b valid=%b required ready=1 valid=0", req_ready, resp_valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ram[8] !== 32'hF00D0000 || ram[9] !== 32'h0) begin
      errors++;
      $display("FAIL rst_split_ram got w8=%h w9=%h required w8=f00d0000 w9=00000000", ram[8], ram[9]);
    end
    sh[32'h22] = 8'h0D;
    sh[32'h23] = 8'hF0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < NW; i++) ram[i] = 32'h0;
    for (int i = 0; i < NB; i++) sh[i] = 8'h0;
    test_reset();
    test_aligned();
    test_subword();
    test_split_load();
    test_split_store();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_split();
    do_access(1'b0, F3_LW, 32'h20, 32'h0, 32'hF00D0000, 2, "lw_after_rst");
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_resp got=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
